// File: rtl/vram_slot_scheduler.sv
// Time-slot scheduler for the single-port tile VRAM.
// Each character cell of SLOTS pixel clocks opens with up to VIDEO_SLOTS
// video fetch slots (only when the cell is video-owned). Every other slot
// is offered to the CPU through a request/ack handshake. The VRAM has a
// 1-clock read latency, so read data is returned the clock after an issue.
module vram_slot_scheduler #(
    parameter int AW          = 14,
    parameter int DW          = 8,
    parameter int SLOTS       = 8,
    parameter int VIDEO_SLOTS = 2
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          PHASE_SYNC,
    input  logic          VID_ACTIVE,
    input  logic [AW-1:0] VID_ADDR,
    output logic [2:0]    VID_SEL,
    output logic          VID_STB,
    output logic [2:0]    VID_TAG,
    output logic [DW-1:0] VID_DATA,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_WDATA,
    output logic          CPU_ACK,
    output logic [DW-1:0] CPU_RDATA,
    output logic [AW-1:0] RAM_ADDR,
    output logic          RAM_WE,
    output logic [DW-1:0] RAM_WDATA,
    input  logic [DW-1:0] RAM_RDATA
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(SLOTS - 1);
    localparam logic [PW-1:0] VID_PHASES = PW'(VIDEO_SLOTS);

    // CPU access FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Phase / ownership
    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] phase;
    logic          own_reg;
    logic          own;
    logic          video_slot;

    // CPU access
    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic          cpu_issue;
    logic          data_phase;
    logic          cpu_we_reg;
    logic [DW-1:0] cpu_rdata_reg;
    logic [DW-1:0] cpu_rdata_next;

    // RAM bus hold registers
    logic [AW-1:0] ram_addr_reg;
    logic [AW-1:0] ram_addr_next;
    logic [DW-1:0] ram_wdata_reg;
    logic [DW-1:0] ram_wdata_next;

    // Video return path
    logic [2:0]    vid_sel_reg;
    logic [2:0]    vid_sel_next;
    logic          vid_stb_reg;
    logic [2:0]    vid_tag_reg;
    logic [2:0]    vid_tag_next;
    logic [DW-1:0] vid_data_reg;
    logic [DW-1:0] vid_data_next;

    // Current phase, next counter value and slot ownership for this clock.
    // PHASE_SYNC forces phase 0 immediately, so the sync cycle is already
    // a (potential) video slot and ownership is taken from VID_ACTIVE live.
    always_comb begin
        phase      = PHASE_SYNC ? '0 : cnt_reg;
        cnt_next   = (phase == LAST_PHASE) ? '0 : phase + PW'(1);
        own        = (phase == '0) ? VID_ACTIVE : own_reg;
        video_slot = own && (phase < VID_PHASES) && !RESET;
    end

    // CPU issue decision and FSM next state.
    always_comb begin
        cpu_issue  = (state_reg == ST_IDLE) && CPU_REQ && !video_slot && !RESET;
        data_phase = (state_reg == ST_DATA);
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cpu_issue) state_next = ST_DATA;
            ST_DATA: state_next = ST_HOLD;
            ST_HOLD: if (!CPU_REQ) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus multiplexing; values not driven by a slot hold their last value.
    always_comb begin
        vid_sel_next   = video_slot ? 3'(phase) : vid_sel_reg;
        vid_tag_next   = video_slot ? 3'(phase) : vid_tag_reg;
        ram_addr_next  = video_slot ? VID_ADDR
                       : (cpu_issue ? CPU_ADDR : ram_addr_reg);
        ram_wdata_next = cpu_issue ? CPU_WDATA : ram_wdata_reg;
        // Read data belongs to whoever issued on the previous clock.
        vid_data_next  = vid_stb_reg ? RAM_RDATA : vid_data_reg;
        cpu_rdata_next = (data_phase && !cpu_we_reg) ? RAM_RDATA : cpu_rdata_reg;
    end

    // Output drive; everything is forced low while RESET is asserted.
    always_comb begin
        VID_SEL   = RESET ? '0 : vid_sel_next;
        VID_STB   = vid_stb_reg && !RESET;
        VID_TAG   = RESET ? '0 : vid_tag_reg;
        VID_DATA  = RESET ? '0 : vid_data_next;
        CPU_ACK   = data_phase && !RESET;
        CPU_RDATA = RESET ? '0 : cpu_rdata_next;
        RAM_ADDR  = RESET ? '0 : ram_addr_next;
        RAM_WE    = cpu_issue && CPU_WE;
        RAM_WDATA = RESET ? '0 : ram_wdata_next;
    end

    // Phase counter and cell ownership registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_reg <= '0;
            own_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            own_reg <= own;
        end
    end

    // CPU FSM state and the access type remembered for the DATA clock.
    // Reset drops any access in flight, so no ACK follows a reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            cpu_we_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cpu_issue) begin
                cpu_we_reg <= CPU_WE;
            end
        end
    end

    // Held copies of the RAM bus and CPU read data.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            cpu_rdata_reg <= '0;
        end else begin
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            cpu_rdata_reg <= cpu_rdata_next;
        end
    end

    // Video return pipeline: strobe and tag one clock after each fetch.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            vid_sel_reg  <= '0;
            vid_stb_reg  <= 1'b0;
            vid_tag_reg  <= '0;
            vid_data_reg <= '0;
        end else begin
            vid_sel_reg  <= vid_sel_next;
            vid_stb_reg  <= video_slot;
            vid_tag_reg  <= vid_tag_next;
            vid_data_reg <= vid_data_next;
        end
    end

    // A video slot never carries a write, and ACK is a single-clock pulse.
    a_no_write_in_video: assert property (@(posedge CLOCK) disable iff (RESET)
        !(video_slot && RAM_WE));
    a_ack_pulse: assert property (@(posedge CLOCK) disable iff (RESET)
        CPU_ACK |=> !CPU_ACK);

endmodule

// File: tb/tb_vram_slot_scheduler.sv
// Bench for vram_slot_scheduler: a VRAM model, a cycle-level reference of
// the slot rules, a vector table, directed corner sequences and a random run.
module tb_vram_slot_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, psync, vact;
    logic [13:0] vaddr;
    logic [2:0]  vsel, vtag;
    logic        vstb;
    logic [7:0]  vdata;
    logic        creq, cwe, cack;
    logic [13:0] caddr;
    logic [7:0]  cwdata, crdata;
    logic [13:0] raddr;
    logic        rwe;
    logic [7:0]  rwdata, rrdata;

    vram_slot_scheduler dut (
        .CLOCK(clk), .RESET(rst), .PHASE_SYNC(psync), .VID_ACTIVE(vact),
        .VID_ADDR(vaddr), .VID_SEL(vsel), .VID_STB(vstb), .VID_TAG(vtag),
        .VID_DATA(vdata), .CPU_REQ(creq), .CPU_WE(cwe), .CPU_ADDR(caddr),
        .CPU_WDATA(cwdata), .CPU_ACK(cack), .CPU_RDATA(crdata),
        .RAM_ADDR(raddr), .RAM_WE(rwe), .RAM_WDATA(rwdata), .RAM_RDATA(rrdata)
    );

    // Synchronous VRAM, read-before-write, 1-clock read latency
    logic [7:0] vram [0:16383];
    always @(posedge clk) begin
        if (rwe) vram[raddr] <= rwdata;
        rrdata <= vram[raddr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        int t;
        t = (a * 13) ^ (a >> 6);
        return t[7:0];
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:16383];
    int m_cnt, m_sel, m_last_addr, m_last_wdata, m_tag, m_stb_data;
    int m_vdata_hold, m_rdata_hold, m_ack_data, m_ack_addr;
    bit m_own, m_stb_due, m_ack_due, m_ack_rd, m_hold;
    int m_ph;
    bit m_vown, m_vid, m_issue;
    int e_sel, e_addr, e_we, e_wdata, e_stb, e_tag, e_vdata, e_ack, e_rdata;
    int cyc = 0, req_start = -1, ack_cnt = 0, we_cnt = 0, xact = 0;

    task automatic model_reset();
        m_cnt = 0; m_sel = 0; m_last_addr = 0; m_last_wdata = 0; m_tag = 0;
        m_stb_data = 0; m_vdata_hold = 0; m_rdata_hold = 0; m_ack_data = 0;
        m_ack_addr = 0; m_own = 0; m_stb_due = 0; m_ack_due = 0; m_ack_rd = 0;
        m_hold = 0; req_start = -1;
    endtask

    task automatic model_eval();
        if (rst) begin
            m_vid = 0; m_issue = 0;
            e_sel = 0; e_addr = 0; e_we = 0; e_wdata = 0; e_stb = 0;
            e_tag = 0; e_vdata = 0; e_ack = 0; e_rdata = 0;
            return;
        end
        m_ph    = psync ? 0 : m_cnt;
        m_vown  = (m_ph == 0) ? vact : m_own;
        m_vid   = m_vown && (m_ph < 2);
        m_issue = creq && !m_vid && !m_ack_due && !m_hold;
        e_sel   = m_vid ? m_ph : m_sel;
        e_addr  = m_vid ? int'(vaddr) : (m_issue ? int'(caddr) : m_last_addr);
        e_we    = (m_issue && cwe) ? 1 : 0;
        e_wdata = m_issue ? int'(cwdata) : m_last_wdata;
        e_stb   = m_stb_due ? 1 : 0;
        e_tag   = m_tag;
        e_vdata = m_stb_due ? m_stb_data : m_vdata_hold;
        e_ack   = m_ack_due ? 1 : 0;
        e_rdata = (m_ack_due && m_ack_rd) ? m_ack_data : m_rdata_hold;
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
            return;
        end
        m_cnt = (m_ph == 7) ? 0 : m_ph + 1;
        m_own = m_vown;
        m_sel = e_sel; m_last_addr = e_addr; m_last_wdata = e_wdata;
        m_vdata_hold = e_vdata; m_rdata_hold = e_rdata;
        if (m_hold && !creq) m_hold = 0;
        if (m_ack_due) begin m_ack_due = 0; m_hold = 1; end
        m_stb_due = m_vid;
        if (m_vid) begin m_tag = m_ph; m_stb_data = int'(ref_mem[vaddr]); end
        if (m_issue) begin
            m_ack_due = 1; m_ack_rd = !cwe; m_ack_addr = int'(caddr);
            m_ack_data = cwe ? int'(cwdata) : int'(ref_mem[caddr]);
            if (cwe) ref_mem[caddr] = cwdata;
        end
    endtask

    // First half of a clock: inputs are already applied at the falling edge.
    task automatic tick_pre();
        #2;
        model_eval();
        if (!rst && creq && !m_ack_due && !m_hold && req_start < 0) req_start = cyc;
        chk("vid_sel",   vsel,   e_sel);
        chk("ram_addr",  raddr,  e_addr);
        chk("ram_we",    rwe,    e_we);
        chk("ram_wdata", rwdata, e_wdata);
        chk("vid_stb",   vstb,   e_stb);
        chk("vid_tag",   vtag,   e_tag);
        chk("vid_data",  vdata,  e_vdata);
        chk("cpu_ack",   cack,   e_ack);
        chk("cpu_rdata", crdata, e_rdata);
        if (cack === 1'b1) ack_cnt++;
        if (rwe === 1'b1) we_cnt++;
        if (e_ack != 0) begin
            xact++;
            chk("cpu_latency_le3", (cyc - req_start <= 3) ? 1 : 0, 1);
            $display("xact %0d: %s addr=%04h data=%02h latency=%0d", xact,
                     m_ack_rd ? "rd" : "wr", m_ack_addr, m_ack_data, cyc - req_start);
            req_start = -1;
        end
    endtask

    task automatic tick_post();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic do_reset();
        rst = 1; psync = 0; creq = 0; cwe = 0;
        tick(); tick();
        rst = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        sync, vact;
        logic [13:0] vaddr;
        logic        req, we;
        logic [13:0] caddr;
        logic [7:0]  wd;
        logic [13:0] e_addr;
        logic        e_we;
        logic [2:0]  e_sel;
        logic        e_stb;
        logic [2:0]  e_tag;
        logic [7:0]  e_vdata;
        logic        e_ack;
        logic [7:0]  e_rdata;
    } vec_t;

    function automatic vec_t mk(input int s, input int va, input int vad, input int rq,
                                input int w, input int ca, input int wd, input int ea,
                                input int ewe, input int esel, input int estb, input int etag,
                                input int evd, input int eack, input int erd);
        vec_t v;
        v.sync = 1'(s); v.vact = 1'(va); v.vaddr = 14'(vad); v.req = 1'(rq);
        v.we = 1'(w); v.caddr = 14'(ca); v.wd = 8'(wd); v.e_addr = 14'(ea);
        v.e_we = 1'(ewe); v.e_sel = 3'(esel); v.e_stb = 1'(estb); v.e_tag = 3'(etag);
        v.e_vdata = 8'(evd); v.e_ack = 1'(eack); v.e_rdata = 8'(erd);
        return v;
    endfunction

    vec_t tbl [16];
    int   we_at, ack_at, acks0, wes0, rd_seen;
    logic [7:0] rd_val;
    int   dr_state, dr_cnt, sync_cnt;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; psync = 0; vact = 0; vaddr = '0; creq = 0; cwe = 0;
        caddr = '0; cwdata = '0;
        for (int i = 0; i < 16384; i++) begin
            vram[i] = init_byte(i);
            ref_mem[i] = init_byte(i);
        end
        model_reset();
        @(negedge clk);

        // Reset held 2 clocks with a CPU request up: outputs stay 0,
        // then the first ACK comes one clock after the first CPU slot.
        creq = 1; cwe = 1; caddr = 14'h0010; cwdata = 8'h5A;
        tick(); tick();
        rst = 0; vact = 1; ack_at = -1; acks0 = ack_cnt;
        for (int k = 0; k < 8; k++) begin
            psync = (k == 0);
            tick_pre();
            if (cack === 1'b1 && ack_at < 0) ack_at = k;
            tick_post();
        end
        chk("t1_first_ack_cycle", ack_at, 3);
        chk("t1_ack_count", ack_cnt - acks0, 1);
        creq = 0; tick();

        // Vector table: video fetch cell, then a CPU read in a non-video cell.
        do_reset();
        tbl[0] = mk(1, 1, 'h0123, 0, 0, 0, 0, 'h0123, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 'h2345, 0, 0, 0, 0, 'h2345, 0, 1, 1, 0, init_byte('h0123), 0, 0);
        tbl[2] = mk(0, 1, 'h3FFF, 0, 0, 0, 0, 'h2345, 0, 1, 1, 1, init_byte('h2345), 0, 0);
        for (int r = 3; r < 8; r++)
            tbl[r] = mk(0, 1, 'h3FFF, 0, 0, 0, 0, 'h2345, 0, 1, 0, 1, init_byte('h2345), 0, 0);
        tbl[8] = mk(1, 0, 'h0777, 1, 0, 'h0042, 0, 'h0042, 0, 1, 0, 1, init_byte('h2345), 0, 0);
        tbl[9] = mk(0, 0, 'h0777, 1, 0, 'h0042, 0, 'h0042, 0, 1, 0, 1, init_byte('h2345), 1,
                    init_byte('h0042));
        for (int r = 10; r < 16; r++)
            tbl[r] = mk(0, 0, 'h0777, 0, 0, 'h0042, 0, 'h0042, 0, 1, 0, 1, init_byte('h2345), 0,
                        init_byte('h0042));
        for (int r = 0; r < 16; r++) begin
            psync = tbl[r].sync; vact = tbl[r].vact; vaddr = tbl[r].vaddr;
            creq = tbl[r].req; cwe = tbl[r].we; caddr = tbl[r].caddr; cwdata = tbl[r].wd;
            tick_pre();
            chk($sformatf("tbl%0d_ram_addr", r), raddr, tbl[r].e_addr);
            chk($sformatf("tbl%0d_ram_we", r), rwe, tbl[r].e_we);
            chk($sformatf("tbl%0d_vid_sel", r), vsel, tbl[r].e_sel);
            chk($sformatf("tbl%0d_vid_stb", r), vstb, tbl[r].e_stb);
            chk($sformatf("tbl%0d_vid_tag", r), vtag, tbl[r].e_tag);
            chk($sformatf("tbl%0d_vid_data", r), vdata, tbl[r].e_vdata);
            chk($sformatf("tbl%0d_cpu_ack", r), cack, tbl[r].e_ack);
            chk($sformatf("tbl%0d_cpu_rdata", r), crdata, tbl[r].e_rdata);
            tick_post();
        end

        // Write raised at phase 0 of a video cell: write at phase 2, ACK at 3.
        do_reset();
        vact = 1; creq = 1; cwe = 1; caddr = 14'h1000; cwdata = 8'hA5;
        we_at = -1; ack_at = -1;
        for (int k = 0; k < 6; k++) begin
            psync = (k == 0);
            tick_pre();
            if (rwe === 1'b1 && we_at < 0) we_at = k;
            if (cack === 1'b1 && ack_at < 0) ack_at = k;
            tick_post();
        end
        chk("t3_write_phase", we_at, 2);
        chk("t3_ack_phase", ack_at, 3);
        psync = 0; creq = 0; tick();
        creq = 1; cwe = 0; caddr = 14'h1000; rd_seen = 0; rd_val = '0;
        for (int k = 0; k < 10; k++) begin
            tick_pre();
            if (cack === 1'b1 && rd_seen == 0) begin rd_seen = 1; rd_val = crdata; end
            tick_post();
        end
        chk("t3_read_acked", rd_seen, 1);
        chk("t3_read_data", rd_val, 8'hA5);
        creq = 0; tick();

        // REQ held 20 clocks after ACK: one access only; drop and re-raise: one more.
        creq = 1; cwe = 1; caddr = 14'h0005; cwdata = 8'h3C;
        acks0 = ack_cnt; wes0 = we_cnt;
        for (int k = 0; k < 24; k++) tick();
        chk("t5_single_ack", ack_cnt - acks0, 1);
        chk("t5_single_write", we_cnt - wes0, 1);
        creq = 0; tick();
        creq = 1; cwdata = 8'h3D; acks0 = ack_cnt;
        for (int k = 0; k < 6; k++) tick();
        chk("t5_second_ack", ack_cnt - acks0, 1);
        creq = 0; tick();

        // Reset while the issued access waits for its ACK: the ACK is dropped.
        vact = 0; psync = 1; creq = 1; cwe = 0; caddr = 14'h0042;
        tick();
        psync = 0; rst = 1; creq = 0; acks0 = ack_cnt;
        tick();
        rst = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_drops_ack", ack_cnt - acks0, 0);

        // Early PHASE_SYNC at phase 5 with a request pending; VID_ACTIVE dropped at phase 1.
        do_reset();
        vact = 1; vaddr = 14'h1111; ack_at = -1;
        for (int k = 0; k < 12; k++) begin
            psync = (k == 0) || (k == 5);
            if (k == 5) begin creq = 1; cwe = 0; caddr = 14'h0042; end
            if (k == 6) vact = 0;
            tick_pre();
            if (k == 6) begin
                chk("t6_ph1_vid_sel", vsel, 1);
                chk("t6_ph1_ram_addr", raddr, 14'h1111);
            end
            if (k == 7) chk("t6_issue_addr", raddr, 14'h0042);
            if (cack === 1'b1 && ack_at < 0) ack_at = k;
            tick_post();
        end
        chk("t6_ack_cycle", ack_at, 8);
        creq = 0; psync = 0; tick();

        // Random traffic against the reference model.
        do_reset();
        dr_state = 0; dr_cnt = 2; sync_cnt = 0;
        for (int n = 0; n < 2500; n++) begin
            psync = (sync_cnt == 0) && ($urandom_range(0, 7) != 0);
            sync_cnt = (sync_cnt == 7) ? 0 : sync_cnt + 1;
            if ($urandom_range(0, 9) == 0) vact = ~vact;
            vaddr = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 15)) : 14'($urandom);
            if (dr_state == 0) begin
                if (dr_cnt == 0) begin
                    creq = 1; cwe = 1'($urandom_range(0, 1));
                    caddr = 14'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 14'h2000 : 14'h0);
                    cwdata = 8'($urandom);
                    dr_state = 1;
                end else dr_cnt--;
            end else if (dr_state == 2) begin
                if (dr_cnt == 0) begin
                    creq = 0; dr_state = 0; dr_cnt = $urandom_range(0, 4);
                end else dr_cnt--;
            end
            tick_pre();
            if (dr_state == 1 && e_ack != 0) begin
                dr_state = 2;
                dr_cnt = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
            end
            tick_post();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
